// File: rtl/prog_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_fifo_mem
// Description : FIFO storage, one write port and one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_fifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset on the array so a RAM macro can drop in here.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/prog_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prog_fifo
// Description : Synchronous FIFO with programmable almost-full/empty flags,
//               sticky error flags and selectable FWFT or registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 128,
    parameter  int FWFT  = 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [LVL_W-1:0] af_thresh_i,
    input  logic [LVL_W-1:0] ae_thresh_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int               c_ADDR_W    = LVL_W - 1;
    localparam logic [LVL_W-1:0] c_DEPTH_LVL = LVL_W'(DEPTH);

    logic [LVL_W-1:0] r_wptr;
    logic [LVL_W-1:0] r_rptr;
    logic             r_ovf;
    logic             r_udf;
    logic [LVL_W-1:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_mem_rdata;

    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    assign w_level  = r_wptr - r_rptr;
    assign w_full   = (w_level == c_DEPTH_LVL);
    assign w_empty  = (w_level == '0);
    assign w_wr_acc = we_i & ~w_full;
    assign w_rd_acc = re_i & ~w_empty;

    assign level_o        = w_level;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (w_level >= af_thresh_i);
    assign almost_empty_o = (w_level <= ae_thresh_i);
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_udf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + LVL_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + LVL_W'(1);
            end
            // A new error wins over a simultaneous clear.
            if (we_i && w_full) begin
                r_ovf <= 1'b1;
            end else if (err_clr_i) begin
                r_ovf <= 1'b0;
            end
            if (re_i && w_empty) begin
                r_udf <= 1'b1;
            end else if (err_clr_i) begin
                r_udf <= 1'b0;
            end
        end
    end

    prog_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(c_ADDR_W)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (w_wr_acc & ~flush_i),
        .waddr_i(r_wptr[c_ADDR_W-1:0]),
        .wdata_i(wdata_i),
        .raddr_i(r_rptr[c_ADDR_W-1:0]),
        .rdata_o(w_mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata_o  = w_empty ? '0 : w_mem_rdata;
            assign rvalid_o = 1'b0;
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (flush_i) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_mem_rdata;
                    end
                end
            end

            assign rdata_o  = r_rdata;
            assign rvalid_o = r_rvalid;
        end
    endgenerate

endmodule
`default_nettype wire
